// File: rtl/ecrc_pkg.sv
// Shared definitions for the streaming PCIe ECRC engine: FSM encoding,
// polynomial/seed defaults and the per-DW CRC-32 update and output mapping.
package ecrc_pkg;

  localparam logic [31:0] ECRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] ECRC_SEED = 32'hFFFF_FFFF;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // One 32-bit MSB-first CRC-32 step.
  function automatic logic [31:0] crc32_dw_next(
    input logic [31:0] remainder,
    input logic [31:0] dw,
    input logic [31:0] poly = ECRC_POLY
  );
    logic [31:0] r;
    logic        fb;
    r = remainder;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31] ^ dw[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ poly;
    end
    return r;
  endfunction

  // PCIe ECRC presentation: complement the remainder, bit-reverse within each byte.
  function automatic logic [31:0] pcie_ecrc_map(input logic [31:0] remainder);
    logic [31:0] c;
    logic [31:0] m;
    c = ~remainder;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        m[8*b + i] = c[8*b + 7 - i];
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ecrc_dw_chain.sv
// Unrolled CRC-32 update across every DW slot of a beat; the clamped DW count
// picks which intermediate remainder is the beat's result.
module ecrc_dw_chain
  import ecrc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned LENGTH_WIDTH = 4,
  parameter logic [31:0] POLY         = ECRC_POLY
) (
  input  logic [31:0]             crc_seed,
  input  logic [DATA_WIDTH-1:0]   beat_data,
  input  logic [LENGTH_WIDTH-1:0] num_dw,
  output logic [31:0]             crc_rem
);

  localparam int unsigned NumDw = DATA_WIDTH / 32;

  logic [31:0] stage [NumDw+1];

  assign stage[0] = crc_seed;

  for (genvar k = 0; k < NumDw; k++) begin : g_stage
    assign stage[k+1] = crc32_dw_next(stage[k], beat_data[DATA_WIDTH-1-32*k -: 32], POLY);
  end

  // num_dw is already clamped to NumDw by the caller; 0 passes the seed through.
  always_comb begin
    crc_rem = stage[0];
    for (int k = 1; k <= NumDw; k++) begin
      if (int'(num_dw) == k) crc_rem = stage[k];
    end
  end

endmodule

// File: rtl/ecrc_stream_engine.sv
// Multi-beat PCIe ECRC generator/checker: accumulates CRC-32 over a TLP streamed
// as DW-counted beats and presents the mapped ECRC with a valid/ready handshake.
module ecrc_stream_engine
  import ecrc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned LENGTH_WIDTH = 4,
  parameter int unsigned POLY_WIDTH   = 32,
  parameter logic [31:0] POLY         = ECRC_POLY,
  parameter logic [31:0] SEED         = ECRC_SEED,
  parameter bit          MASK_VARIANT = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_n_rst,
  input  logic                    ECRC_i_Valid,
  output logic                    ECRC_o_Ready,
  input  logic                    ECRC_i_SOP,
  input  logic                    ECRC_i_EOP,
  input  logic [DATA_WIDTH-1:0]   ECRC_i_Data,
  input  logic [LENGTH_WIDTH-1:0] ECRC_i_Length,
  input  logic                    ECRC_i_Mode,
  input  logic [31:0]             ECRC_i_Expected,
  output logic                    ECRC_o_Valid,
  input  logic                    ECRC_i_Ready,
  output logic [31:0]             ECRC_o_CRC,
  output logic                    ECRC_o_Match,
  output logic                    ECRC_o_Err
);

  localparam int unsigned NumDw = DATA_WIDTH / 32;

  logic [1:0]            state_q, state_d;
  logic [POLY_WIDTH-1:0] rem_q, rem_d;
  logic                  mode_q, mode_d;
  logic [31:0]           res_crc_q, res_crc_d;
  logic                  res_match_q, res_match_d;
  logic                  err_q, err_d;

  logic                    accept;
  logic                    in_tlp;
  logic                    apply;
  logic                    len_over;
  logic                    cur_mode;
  logic [LENGTH_WIDTH-1:0] num_dw;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic [31:0]             chain_seed;
  logic [31:0]             chain_rem;
  logic [31:0]             final_crc;

  // Ready drops only while a finished result waits for its consumer.
  assign ECRC_o_Ready = (state_q != StDone) | ECRC_i_Ready;
  assign ECRC_o_Valid = (state_q == StDone);
  assign ECRC_o_CRC   = res_crc_q;
  assign ECRC_o_Match = res_match_q;
  assign ECRC_o_Err   = err_q;

  assign accept   = ECRC_i_Valid & ECRC_o_Ready;
  assign in_tlp   = (state_q == StAccum);
  assign apply    = accept & (ECRC_i_SOP | in_tlp);
  assign len_over = 32'(ECRC_i_Length) > NumDw;
  assign num_dw   = len_over ? LENGTH_WIDTH'(NumDw) : ECRC_i_Length;
  assign cur_mode = ECRC_i_SOP ? ECRC_i_Mode : mode_q;

  // A SOP beat always restarts from SEED, which also covers the mid-TLP abort.
  assign chain_seed = ECRC_i_SOP ? SEED : rem_q;
  assign final_crc  = pcie_ecrc_map(chain_rem);

  always_comb begin
    beat_data = ECRC_i_Data;
    if (MASK_VARIANT && ECRC_i_SOP) begin
      beat_data[DATA_WIDTH-32+24] = 1'b1;
      beat_data[DATA_WIDTH-32+14] = 1'b1;
    end
  end

  ecrc_dw_chain #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LENGTH_WIDTH(LENGTH_WIDTH),
    .POLY        (POLY)
  ) u_chain (
    .crc_seed (chain_seed),
    .beat_data(beat_data),
    .num_dw   (num_dw),
    .crc_rem  (chain_rem)
  );

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    mode_d      = mode_q;
    res_crc_d   = res_crc_q;
    res_match_d = res_match_q;
    err_d       = 1'b0;

    if (state_q == StDone && ECRC_i_Ready) state_d = StIdle;

    // SOP inside a TLP aborts it; a non-SOP beat outside a TLP is dropped.
    if (accept) err_d = len_over | (ECRC_i_SOP == in_tlp);

    if (apply) begin
      rem_d  = chain_rem;
      mode_d = cur_mode;
      if (ECRC_i_EOP) begin
        state_d     = StDone;
        res_crc_d   = final_crc;
        res_match_d = cur_mode & (final_crc == ECRC_i_Expected);
      end else begin
        state_d = StAccum;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      state_q     <= StIdle;
      rem_q       <= SEED;
      mode_q      <= 1'b0;
      res_crc_q   <= '0;
      res_match_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      res_crc_q   <= res_crc_d;
      res_match_q <= res_match_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ecrc_stream_engine.sv
// Directed bench for ecrc_stream_engine against a bit-serial CRC-32 reference.
module tb_ecrc_stream_engine;

  localparam int unsigned DW = 256;

  typedef logic [31:0] dw_arr_t [16];

  logic          clk = 1'b0;
  logic          n_rst;
  logic          in_valid, in_ready, sop, eop, mode;
  logic [DW-1:0] data;
  logic [3:0]    length;
  logic [31:0]   expected;
  logic          out_valid, out_ready, match, err;
  logic [31:0]   crc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ecrc_stream_engine dut (
    .i_clk          (clk),
    .i_n_rst        (n_rst),
    .ECRC_i_Valid   (in_valid),
    .ECRC_o_Ready   (in_ready),
    .ECRC_i_SOP     (sop),
    .ECRC_i_EOP     (eop),
    .ECRC_i_Data    (data),
    .ECRC_i_Length  (length),
    .ECRC_i_Mode    (mode),
    .ECRC_i_Expected(expected),
    .ECRC_o_Valid   (out_valid),
    .ECRC_i_Ready   (out_ready),
    .ECRC_o_CRC     (crc),
    .ECRC_o_Match   (match),
    .ECRC_o_Err     (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Bit-serial reference over a whole TLP; DW0 carries the Type[0]/EP mask.
  function automatic logic [31:0] ref_ecrc(input dw_arr_t d, input int n);
    logic [31:0] r;
    logic [31:0] w;
    logic [31:0] o;
    logic        b;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      w = d[i];
      if (i == 0) w = w | 32'h0100_4000;
      for (int j = 31; j >= 0; j--) begin
        b = r[31] ^ w[j];
        r = r << 1;
        if (b) r = r ^ 32'h04C1_1DB7;
      end
    end
    r = ~r;
    for (int k = 0; k < 32; k++) o[(k / 8) * 8 + 7 - (k % 8)] = r[k];
    return o;
  endfunction

  function automatic logic [DW-1:0] pack_beat(input dw_arr_t d, input int start, input int n);
    logic [DW-1:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[DW-1-32*i -: 32] = d[start+i];
    return b;
  endfunction

  task automatic send_beat(input logic [DW-1:0] bdata, input int len, input bit bsop,
                           input bit beop, input bit bmode, input logic [31:0] bexp,
                           output logic err_seen);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    data     = bdata;
    length   = 4'(len);
    sop      = bsop;
    eop      = beop;
    mode     = bmode;
    expected = bexp;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("beat_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    err_seen = err;
    in_valid = 1'b0;
    sop      = 1'b0;
    eop      = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic [31:0] want_crc, input bit want_match);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_crc"}, crc, want_crc);
    check_eq({tag, "_match"}, 32'(match), 32'(want_match));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dw_arr_t     a;
    dw_arr_t     b;
    logic        e;
    logic [31:0] crc1, crc_a, crc_b, want;

    n_rst = 1'b0; in_valid = 1'b0; sop = 1'b0; eop = 1'b0; mode = 1'b0;
    data = '0; length = '0; expected = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_crc", crc, 32'd0);
    check_eq("rst_match", 32'(match), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Single 4-DW beat, generate mode.
    a = '{default: 32'h0};
    a[0] = 32'h2000_8001;
    crc1 = ref_ecrc(a, 4);
    send_beat(pack_beat(a, 0, 4), 4, 1, 1, 0, 32'h0, e);
    check_eq("t1_err", 32'(e), 32'd0);
    check_eq("t1_latency", 32'(out_valid), 32'd1);
    take_result("t1", crc1, 1'b0);

    // 12-DW TLP split 8+4 and 4+4+4.
    for (int i = 0; i < 12; i++) a[i] = 32'h1111_1111 * (i + 1);
    a[0] = 32'h4000_000C;
    want = ref_ecrc(a, 12);
    send_beat(pack_beat(a, 0, 8), 8, 1, 0, 0, 32'h0, e);
    send_beat(pack_beat(a, 8, 4), 4, 0, 1, 0, 32'h0, e);
    take_result("split84", want, 1'b0);
    send_beat(pack_beat(a, 0, 4), 4, 1, 0, 0, 32'h0, e);
    send_beat(pack_beat(a, 4, 4), 4, 0, 0, 0, 32'h0, e);
    send_beat(pack_beat(a, 8, 4), 4, 0, 1, 0, 32'h0, e);
    check_eq("split444_err", 32'(e), 32'd0);
    take_result("split444", want, 1'b0);

    // Check mode, correct and corrupted expected value.
    a = '{default: 32'h0};
    a[0] = 32'h2000_8001;
    send_beat(pack_beat(a, 0, 4), 4, 1, 1, 1, crc1, e);
    take_result("chk_ok", crc1, 1'b1);
    send_beat(pack_beat(a, 0, 4), 4, 1, 1, 1, crc1 ^ 32'h1, e);
    take_result("chk_bad", crc1, 1'b0);

    // Back-to-back with consumer stall; both handshakes in one cycle.
    a = '{default: 32'h0};
    a[0] = 32'hDEAD_BEEF; a[1] = 32'h0123_4567; a[2] = 32'h89AB_CDEF;
    crc_a = ref_ecrc(a, 3);
    b = '{default: 32'h0};
    b[0] = 32'h0000_0001; b[1] = 32'hCAFE_F00D;
    crc_b = ref_ecrc(b, 2);
    send_beat(pack_beat(a, 0, 3), 3, 1, 1, 0, 32'h0, e);
    @(negedge clk);
    in_valid = 1'b1; data = pack_beat(b, 0, 2); length = 4'd2;
    sop = 1'b1; eop = 1'b1; mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_crc", crc, crc_a);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    check_eq("b2b_err", 32'(err), 32'd0);
    take_result("b2b_second", crc_b, 1'b0);

    // Stray beat in IDLE.
    send_beat(pack_beat(b, 0, 2), 2, 0, 1, 0, 32'h0, e);
    check_eq("stray_err", 32'(e), 32'd1);
    check_eq("stray_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("stray_err_pulse", 32'(err), 32'd0);

    // SOP mid-TLP aborts; CRC covers only the new TLP.
    a = '{default: 32'h5A5A_5A5A};
    send_beat(pack_beat(a, 0, 4), 4, 1, 0, 0, 32'h0, e);
    check_eq("abort_first_err", 32'(e), 32'd0);
    send_beat(pack_beat(b, 0, 2), 2, 1, 1, 0, 32'h0, e);
    check_eq("abort_err", 32'(e), 32'd1);
    take_result("abort", crc_b, 1'b0);

    // Length 0: remainder stays at seed, so the mapped ECRC is all zeros.
    send_beat(pack_beat(b, 0, 2), 0, 1, 1, 0, 32'h0, e);
    check_eq("len0_err", 32'(e), 32'd0);
    take_result("len0", 32'h0000_0000, 1'b0);

    // Length 15 clamps to 8 DWs.
    for (int i = 0; i < 8; i++) a[i] = 32'h0F1E_2D3C + 32'(i) * 32'h0101_0101;
    want = ref_ecrc(a, 8);
    send_beat(pack_beat(a, 0, 8), 15, 1, 1, 1, want, e);
    check_eq("len15_err", 32'(e), 32'd1);
    take_result("len15", want, 1'b1);

    // Reset mid-ACCUM.
    send_beat(pack_beat(a, 0, 8), 8, 1, 0, 0, 32'h0, e);
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_crc", crc, 32'd0);
    check_eq("mid_rst_match", 32'(match), 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    send_beat(pack_beat(b, 0, 2), 2, 1, 1, 0, 32'h0, e);
    check_eq("post_rst_err", 32'(e), 32'd0);
    take_result("post_rst", crc_b, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ecrc_stream_engine.md
# ecrc_stream_engine

Sequential, multi-beat PCIe ECRC engine for the TL TX/RX data path. It accepts a TLP as a stream of DATA_WIDTH-bit beats with a per-beat DW count and accumulates CRC-32 (polynomial 04C11DB7) across beats. It either generates the final ECRC or checks it against a received value. It is the successor to the single-beat combinational CRC32 units and sits between Data_Fragmentation and the TLP framing stage.

## Interface
Parameters:
- DATA_WIDTH, 256, beat width in bits; multiple of 32.
- LENGTH_WIDTH, 4, width of the per-beat DW count.
- POLY_WIDTH, 32, CRC width; only 32 is supported.
- POLY, 32'h04C11DB7, generator polynomial.
- SEED, 32'hFFFF_FFFF, value loaded at start of every TLP.
- MASK_VARIANT, 1, when 1, header bits Type[0] and EP of the first beat are forced to 1 before the CRC.

Ports:
- i_clk  in  1  clock; one clock for the block.
- i_n_rst  in  1  reset; synchronous, active-low.
- ECRC_i_Valid  in  1  beat valid.
- ECRC_o_Ready  out  1  beat accepted when Valid & Ready.
- ECRC_i_SOP  in  1  first beat of TLP.
- ECRC_i_EOP  in  1  last beat of TLP.
- ECRC_i_Data  in  DATA_WIDTH  beat data; DW0 is at [DATA_WIDTH-1 -: 32], MSB-first, valid DWs left-justified.
- ECRC_i_Length  in  LENGTH_WIDTH  number of valid DWs in the beat, 0..DATA_WIDTH/32.
- ECRC_i_Mode  in  1  0 = generate, 1 = check; sampled on the SOP beat.
- ECRC_i_Expected  in  32  received ECRC; sampled on the EOP beat in check mode.
- ECRC_o_Valid  out  1  result valid.
- ECRC_i_Ready  in  1  consumer accepts the result.
- ECRC_o_CRC  out  32  final ECRC: complement of the remainder, each byte bit-reversed (PCIe mapping).
- ECRC_o_Match  out  1  check mode only: ECRC_o_CRC == ECRC_i_Expected. 0 in generate mode.
- ECRC_o_Err  out  1  one-cycle protocol error pulse.

## Operation
- States are IDLE, ACCUM and DONE. Reset enters IDLE.
- On reset, every output is 0 except ECRC_o_Ready, which is 1. The remainder register is SEED.
- IDLE:
  - An accepted beat with SOP loads SEED, then applies the beat.
  - EOP on that beat goes to DONE. Otherwise the state goes to ACCUM.
  - An accepted beat without SOP is dropped, pulses Err, and stays in IDLE.
- ACCUM:
  - Each accepted beat updates the remainder over its first Length DWs.
  - EOP goes to DONE.
  - SOP in ACCUM aborts the current TLP: pulse Err, reload SEED, apply the beat as a new first beat, and stay in or leave ACCUM per that beat's EOP.
- DONE:
  - Valid is held with CRC, Match and mode stable until ECRC_i_Ready.
  - ECRC_o_Ready = ECRC_i_Ready. A new SOP beat is accepted in the same cycle the result is taken, so TLPs run back-to-back with no bubble.
  - The result hands off to IDLE, or to ACCUM/DONE if a new beat was accepted that cycle.
- Length rules:
  - Length 0 leaves the remainder unchanged but still honours SOP/EOP.
  - Length > DATA_WIDTH/32 is clamped to DATA_WIDTH/32 and pulses Err.
- MASK_VARIANT applies only to DW0 of the SOP beat: bit 24 (Type[0]) and bit 14 (EP) are ORed to 1.
- Deasserting i_n_rst mid-TLP discards all state; no result is produced for the partial TLP.

## Timing
- Throughput is one beat per cycle. The full DATA_WIDTH update is combinational from the registered remainder.
- Latency: ECRC_o_Valid rises the cycle after the EOP beat is accepted.
- Valid/Ready on both sides follows the AXI-stream rule: data is held stable while Valid & !Ready, and Valid never depends on Ready.
- Err is registered and asserts the cycle after the offending beat.

## Structure
- Package ecrc_pkg holds:
  - the state enum;
  - POLY/SEED defaults;
  - function crc32_dw_next(remainder, dw), a 32-bit MSB-first update;
  - function pcie_ecrc_map(remainder), which performs the complement plus per-byte bit reversal.
- Sub-module ecrc_dw_chain chains DATA_WIDTH/32 crc32_dw_next stages and muxes the stage output selected by the clamped Length.

## Test plan
- Single beat, Data = 128'h20008001_00000000_00000000_00000000 left-justified, Length=4, SOP=EOP=1, generate -> CRC equals the serial bit-by-bit reference model, Valid after 1 cycle, Match=0.
- Same 12-DW TLP sent as one 8-DW beat then one 4-DW beat, and as three 4-DW beats -> identical CRC to the single-shot reference.
- Check mode: Expected = CRC from the previous case -> Match=1; Expected with bit 0 flipped -> Match=0.
- Back-to-back TLPs with ECRC_i_Ready=0 for 3 cycles -> result held stable, input Ready=0. Release Ready while the next SOP is valid -> both handshakes complete the same cycle, and the second CRC is correct.
- Error cases:
  - Beat without SOP in IDLE -> Err pulse, no Valid.
  - SOP mid-TLP -> Err pulse, and the CRC covers only the new TLP.
  - Length=15 -> clamped to 8 DWs, Err pulse.
- i_n_rst low for 1 cycle mid-ACCUM -> all outputs return to reset values. The next TLP's CRC matches the model seeded with FFFF_FFFF.
